// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation controller for the on-chip SAR ADC.
//
// Sequences the track/hold phase, drives the capacitor-DAC trial code and
// resolves one result bit per step from the synchronized comparator output.
// Supports single-shot and continuous conversion.
//
// Handshake: start is a level sampled only in IDLE; there is no ready.
// A start seen while busy is dropped, not queued. data_valid is a
// one-cycle pulse, coincident with the data_out update; there is no
// back-pressure.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin a conversion (IDLE only)
//   cont         re-arm automatically after each result
//   abort        cancel the conversion in progress (wins over start)
//   comp_in      raw comparator output, asynchronous to clk
//   sample       track switch enable (1 = tracking Vin)
//   dac_code     trial code to the capacitor DAC
//   busy         1 in every state except IDLE
//   data_out     last completed result
//   data_valid   one-cycle pulse when data_out updates
//   state_dbg    current FSM state encoding, for observation only
module sar_adc_ctrl #(
    parameter int   WIDTH         = 8,
    parameter int   SAMPLE_CYCLES = 4,
    parameter int   SETTLE_CYCLES = 3,
    parameter logic COMP_POL      = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             comp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int MAX_CYC = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sync1_q, sync1_d;
    logic               comp_s_q, comp_s_d;
    logic               sample_q, sample_d;
    logic [WIDTH-1:0]   dac_q, dac_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               dv_q, dv_d;

    logic [WIDTH-1:0]   bit_mask;
    logic [WIDTH-1:0]   decided;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sync1_d  = comp_in;
        comp_s_d = sync1_q;
        sample_d = sample_q;
        dac_d    = dac_q;
        dout_d   = dout_q;
        dv_d     = 1'b0;

        // dac_q already carries the trial bit, so deciding only ever
        // needs to clear it when the comparator says Vin < Vdac.
        bit_mask = WIDTH'(1) << idx_q;
        decided  = (comp_s_q == COMP_POL) ? dac_q : (dac_q & ~bit_mask);

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d  = ST_SAMPLE;
                    cnt_d    = '0;
                    sample_d = 1'b1;
                    dac_d    = '0;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    state_d  = ST_SETTLE;
                    cnt_d    = '0;
                    sample_d = 1'b0;
                    idx_d    = IDX_MSB;
                    dac_d    = {1'b1, {(WIDTH-1){1'b0}}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_DECIDE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECIDE: begin
                if (idx_q != '0) begin
                    state_d = ST_SETTLE;
                    idx_d   = idx_q - IDX_W'(1);
                    dac_d   = decided | (bit_mask >> 1);
                end else begin
                    state_d = ST_DONE;
                    dac_d   = decided;
                    dout_d  = decided;
                    dv_d    = 1'b1;
                end
            end
            ST_DONE: begin
                if (cont) begin
                    state_d  = ST_SAMPLE;
                    cnt_d    = '0;
                    sample_d = 1'b1;
                    dac_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                sample_d = 1'b0;
                dac_d    = '0;
            end
        endcase

        // Abort overrides whatever the state wanted, including a result
        // that would have been produced on this very edge.
        if (abort && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            sample_d = 1'b0;
            dac_d    = '0;
            dout_d   = dout_q;
            dv_d     = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            sync1_q  <= 1'b0;
            comp_s_q <= 1'b0;
            sample_q <= 1'b0;
            dac_q    <= '0;
            busy_q   <= 1'b0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sync1_q  <= sync1_d;
            comp_s_q <= comp_s_d;
            sample_q <= sample_d;
            dac_q    <= dac_d;
            busy_q   <= busy_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
        end
    end

    assign sample     = sample_q;
    assign dac_code   = dac_q;
    assign busy       = busy_q;
    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: an ideal comparator driven by vin, a timeline
// model of the conversion (phase time since start, binary-search trial
// codes), a result scoreboard and directed plus random scenarios.
module tb_sar_adc_ctrl;
  localparam int W      = 8;
  localparam int S      = 4;
  localparam int ST     = 3;
  localparam int T_DONE = S + W * (ST + 1);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (COMP_POL = 1) ----------------
  logic         start = 1'b0;
  logic         cont  = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] vin   = '0;
  logic         comp_in;
  logic         sample, busy, data_valid;
  logic [W-1:0] dac_code, data_out;
  logic [2:0]   state_dbg;

  assign comp_in = (vin >= dac_code) ? 1'b1 : 1'b0;

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(ST), .COMP_POL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
    .comp_in(comp_in), .sample(sample), .dac_code(dac_code), .busy(busy),
    .data_out(data_out), .data_valid(data_valid), .state_dbg(state_dbg)
  );

  // ---------------- inverted-polarity DUT ----------------
  logic         start1 = 1'b0;
  logic [W-1:0] vin1   = '0;
  logic         comp1;
  logic         sample1, busy1, dv1;
  logic [W-1:0] dac1, dout1;
  logic [2:0]   state_dbg1;

  assign comp1 = (vin1 >= dac1) ? 1'b0 : 1'b1;

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(ST), .COMP_POL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cont(1'b0), .abort(1'b0),
    .comp_in(comp1), .sample(sample1), .dac_code(dac1), .busy(busy1),
    .data_out(dout1), .data_valid(dv1), .state_dbg(state_dbg1)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Trial code for step j (0 = MSB): the already-resolved upper bits of vin
  // plus the bit under test.
  function automatic logic [W-1:0] trial(input logic [W-1:0] v, input int j);
    int keep;
    keep = (int'(v) >> (W - j)) << (W - j);
    return W'(keep | (1 << (W - 1 - j)));
  endfunction

  bit           m_busy   = 1'b0;
  int           m_t      = 0;
  logic         m_sample = 1'b0;
  logic [W-1:0] m_dac    = '0;
  logic [W-1:0] m_dout   = '0;
  logic         m_dv     = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_t = 0; m_sample = 1'b0;
      m_dac = '0; m_dout = '0; m_dv = 1'b0;
    end else begin
      m_dv = 1'b0;
      if (!m_busy) begin
        if (start && !abort) begin m_busy = 1'b1; m_t = 0; end
      end else if (abort) begin
        m_busy = 1'b0; m_dac = '0;
      end else if (m_t == T_DONE) begin
        if (cont) m_t = 0;
        else m_busy = 1'b0;
      end else begin
        m_t++;
      end
      if (m_busy) begin
        m_sample = (m_t < S);
        if (m_t < S) m_dac = '0;
        else if (m_t < T_DONE) m_dac = trial(vin, (m_t - S) / (ST + 1));
        else begin m_dac = vin; m_dout = vin; m_dv = 1'b1; end
      end else begin
        m_sample = 1'b0;
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("model_sample", sample, m_sample);
      check("model_busy", busy, m_busy);
      check("model_dac", dac_code, m_dac);
      check("model_data_out", data_out, m_dout);
      check("model_valid", data_valid, m_dv);
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int dv_count = 0;

  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      dv_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_valid actual=0x%0h expected=no_pulse at cycle %0d", data_out, cyc);
      end else begin
        check("sb_result", data_out, exp_q.pop_front());
      end
    end
  end

  // Trial codes as presented to the DAC, for the literal sequence check.
  bit           cap_en = 1'b0;
  logic [W-1:0] last_dac = '0;
  logic [W-1:0] trial_q[$];
  always @(negedge clk) begin
    if (cap_en && busy && !sample && dac_code != last_dac) begin
      trial_q.push_back(dac_code);
      last_dac = dac_code;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_conv(input logic [W-1:0] v, input bit push, output int k);
    @(posedge clk);
    #2;
    vin   = v;
    start = 1'b1;
    if (push) exp_q.push_back(v);
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
  endtask

  task automatic wait_dv(input string name, input int budget, output int at_cyc);
    int n;
    n = 0;
    at_cyc = -1;
    while (n < budget) begin
      @(negedge clk);
      #1;
      if (data_valid) begin
        at_cyc = cyc;
        break;
      end
      n++;
    end
    if (at_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=data_valid within %0d cycles", name, budget);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] t1_trials [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
  logic [W-1:0] t2_vals   [3] = '{8'h00, 8'hFF, 8'h80};

  initial begin
    int k, at, at0, at1, at2, cnt0, n;
    logic [W-1:0] v;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_sample", sample, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dac", dac_code, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_data_out_pol0", dout1, 8'h00);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);

    // 1: vin=0xA5, latency and trial sequence
    trial_q.delete();
    last_dac = '0;
    cap_en = 1'b1;
    start_conv(8'hA5, 1'b1, k);
    wait_dv("t1_wait", 60, at);
    cap_en = 1'b0;
    check("t1_latency", at - k, 36);
    check("t1_result", data_out, 8'hA5);
    check("t1_trial_count", trial_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < trial_q.size()) check($sformatf("t1_trial%0d", i), trial_q[i], t1_trials[i]);
    end
    @(negedge clk);
    #1;
    check("t1_busy_drop", busy, 1'b0);
    check("t1_dac_hold", dac_code, 8'hA5);

    // 4: abort in the third DECIDE
    cnt0 = dv_count;
    start_conv(8'h55, 1'b0, k);
    repeat (15) @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk);
    #2 abort = 1'b0;
    @(negedge clk);
    #1;
    check("t4_busy", busy, 1'b0);
    check("t4_dac", dac_code, 8'h00);
    check("t4_sample", sample, 1'b0);
    check("t4_data_out_kept", data_out, 8'hA5);
    repeat (40) @(negedge clk);
    check("t4_no_valid", dv_count - cnt0, 0);
    start_conv(8'h55, 1'b1, k);
    wait_dv("t4_restart_wait", 60, at);
    check("t4_restart_result", data_out, 8'h55);

    // 2: boundary codes
    for (int i = 0; i < 3; i++) begin
      start_conv(t2_vals[i], 1'b1, k);
      wait_dv("t2_wait", 60, at);
      check($sformatf("t2_result_%0h", t2_vals[i]), data_out, t2_vals[i]);
      repeat (3) @(posedge clk);
    end

    // 3: continuous mode with stepping vin, then cont cleared mid-conversion
    cont = 1'b1;
    start_conv(8'h10, 1'b1, k);
    wait_dv("t3_wait0", 60, at0);
    vin = 8'h20;
    exp_q.push_back(8'h20);
    @(negedge clk);
    #1;
    check("t3_sample_after_done", sample, 1'b1);
    wait_dv("t3_wait1", 60, at1);
    vin = 8'h30;
    exp_q.push_back(8'h30);
    repeat (5) @(negedge clk);
    cont = 1'b0;
    wait_dv("t3_wait2", 60, at2);
    check("t3_period1", at1 - at0, 37);
    check("t3_period2", at2 - at1, 37);
    cnt0 = dv_count;
    repeat (45) @(negedge clk);
    check("t3_idle_after_cont", busy, 1'b0);
    check("t3_no_rearm", dv_count - cnt0, 0);

    // 5: reset mid-SETTLE, then start while busy
    cnt0 = dv_count;
    start_conv(8'h6A, 1'b0, k);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_sample", sample, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_dac", dac_code, 8'h00);
    check("t5_rst_data_out", data_out, 8'h00);
    check("t5_rst_valid", data_valid, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (45) @(negedge clk);
    check("t5_no_valid_after_rst", dv_count - cnt0, 0);
    cnt0 = dv_count;
    start_conv(8'h3E, 1'b1, k);
    repeat (10) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_dv("t5_wait", 60, at);
    repeat (45) @(negedge clk);
    check("t5_one_conversion", dv_count - cnt0, 1);
    check("t5_idle", busy, 1'b0);

    // Random conversions with random idle gaps and an occasional ignored start
    for (int r = 0; r < 6; r++) begin
      v = W'($urandom_range(0, 255));
      start_conv(v, 1'b1, k);
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 30);
        repeat (n) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
      end
      wait_dv("rnd_wait", 60, at);
      n = $urandom_range(1, 6);
      repeat (n) @(posedge clk);
    end
    repeat (40) @(posedge clk);

    // 6: inverted comparator polarity
    vin1 = 8'h3C;
    @(posedge clk);
    #2 start1 = 1'b1;
    @(posedge clk);
    #2 start1 = 1'b0;
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dv1 && at < 0) at = cyc;
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL t6_wait actual=timeout expected=data_valid within 60 cycles");
    end
    check("t6_pol0_result", dout1, 8'h3C);
    check("t6_pol0_idle", busy1, 1'b0);

    check("sb_drained", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Digital successive-approximation controller for the on-chip SAR ADC. It sequences track/hold sampling, drives the capacitor-DAC trial code, and resolves one bit per step from the analog comparator output. It sits between the analog macro (DAC switches and comparator on the ua pins) and the digital user I/O. It supports single-shot and continuous conversion and returns a registered result with a one-cycle valid pulse.

Parameters:
WIDTH, 8, resolution in bits; legal values are 4..12.
SAMPLE_CYCLES, 4, number of cycles sample is held high (track phase); legal values are ≥1.
SETTLE_CYCLES, 3, cycles the DAC code is held before each decision; legal values are ≥2, to cover the 2-flop synchronizer.
COMP_POL, 1, the comp_in level that means Vin ≥ Vdac.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a conversion; sampled in IDLE only
cont  in  1  continuous mode: re-arm automatically after DONE
abort  in  1  cancel the conversion in progress
comp_in  in  1  raw analog comparator output, asynchronous to clk
sample  out  1  track switch enable; 1 = tracking Vin
dac_code  out  WIDTH  trial code to the capacitor DAC
busy  out  1  1 in any state other than IDLE
data_out  out  WIDTH  last completed conversion result, registered
data_valid  out  1  one-cycle pulse when data_out updates

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - sample, busy and data_valid are 0.
  - dac_code and data_out are 0.
  - Synchronizer flops, counters and bit index are cleared.
- comp_in passes through a 2-flop synchronizer to give comp_s. comp_s is used only in DECIDE.
- States: IDLE, SAMPLE, SETTLE, DECIDE, DONE. All outputs are registered.
- IDLE: dac_code holds its last value. If start=1 and abort=0, the next state is SAMPLE.
- SAMPLE:
  - sample=1 and dac_code=0.
  - Stays exactly SAMPLE_CYCLES cycles.
  - On exit, bit index i=WIDTH-1 and the trial code is {1,0..0}.
- SETTLE: sample=0 and dac_code = result | (1<<i). Stays exactly SETTLE_CYCLES cycles, then goes to DECIDE.
- DECIDE (1 cycle):
  - If comp_s==COMP_POL, bit i is kept; otherwise it is cleared.
  - If i>0: i decrements, the next trial sets bit i-1, and the next state is SETTLE.
  - If i==0: next state is DONE.
- DONE (1 cycle):
  - data_out = final result and data_valid=1.
  - dac_code holds the final result.
  - If cont=1 the next state is SAMPLE; otherwise IDLE.
- Latency: with start sampled at edge k, DONE is entered after edge k+SAMPLE_CYCLES+WIDTH*(SETTLE_CYCLES+1). With defaults this is k+36.
- Continuous-mode period is SAMPLE_CYCLES+WIDTH*(SETTLE_CYCLES+1)+1, which is 37 with defaults.
- start while busy is ignored. It is not queued.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, with sample=0 and dac_code=0.
  - No data_valid pulse; data_out keeps its previous value.
- abort=1 together with start=1 in IDLE: stay in IDLE (abort wins).
- abort during DONE: the data_valid pulse of that cycle still occurs, since it is already registered. The next state is IDLE even if cont=1.
- Clearing cont mid-conversion: the current conversion completes, then the block returns to IDLE.
- Reset mid-conversion: all outputs return to reset values immediately (async). No data_valid.
- The result is all-ones when the comparator always reports Vin ≥ Vdac, and all-zeros when it never does. No saturation logic is needed.

Test Plan:
Bench comparator model: comp_in = (vin_code ≥ dac_code) ? COMP_POL : ~COMP_POL, evaluated combinationally.
1. vin=0xA5, pulse start for 1 cycle → sample high for 4 cycles; dac_code trials are 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5; data_out=0xA5 with data_valid for 1 cycle after edge k+36; busy then drops.
2. vin=0x00 → result 0x00. vin=0xFF → result 0xFF. vin=0x80 → result 0x80 (MSB boundary).
3. cont=1, vin stepping 0x10 → 0x20 → 0x30 between conversions → data_valid every 37 cycles; results are 0x10, 0x20, 0x30; sample rises the cycle after each DONE.
4. abort asserted in the 3rd DECIDE of a conversion with vin=0x55 → IDLE next cycle, dac_code=0, no data_valid, data_out keeps the prior 0xA5. A new start then gives 0x55.
5. rst_n low for 1 cycle mid-SETTLE → all outputs are 0 asynchronously (before the next edge). start pulsed during busy → ignored, and the conversion count is unchanged.
6. COMP_POL=0 build with an inverted comparator model, vin=0x3C → data_out=0x3C.
